// File: rtl/fc_flatten_buffer.sv
// Frame buffer and serializer that feeds the fully-connected layer.
// It takes one pixel position per beat, with all channels in parallel, and stores a full
// frame. It then replays the frame one value per cycle in channel-major order, so step k
// carries channel k/P at position k%P.
module fc_flatten_buffer #(
  parameter int unsigned I_BW   = 16,
  parameter int unsigned I_SIZE = 4,
  parameter int unsigned CI     = 12
) (
  input  logic               clk,
  input  logic               global_rst,
  input  logic               user_reset,
  input  logic               i_valid,
  input  logic [CI*I_BW-1:0] i_data,
  output logic               o_busy,
  output logic [I_BW-1:0]    o_data,
  output logic               o_ce,
  output logic               o_done,
  output logic               o_overflow
);

  localparam int unsigned P    = I_SIZE * I_SIZE;
  localparam int unsigned PosW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned ChW  = (CI > 1) ? $clog2(CI) : 1;

  localparam logic [PosW-1:0] LastPos = PosW'(P - 1);
  localparam logic [ChW-1:0]  LastCh  = ChW'(CI - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StDrain,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [PosW-1:0] wr_pos_q, wr_pos_d;
  logic [PosW-1:0] rd_pos_q, rd_pos_d;
  logic [ChW-1:0]  rd_ch_q, rd_ch_d;

  logic [I_BW-1:0] data_q, data_d;
  logic            ce_q, ce_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic            mem_we;
  logic [PosW-1:0] mem_addr;
  logic [I_BW-1:0] rd_val;

  // Frame storage. It is never cleared, because every entry is rewritten before it is read.
  logic [I_BW-1:0] mem [0:P-1][0:CI-1];

  assign rd_val = mem[rd_pos_q][rd_ch_q];

  // Next-state, counter and output decode.
  always_comb begin
    state_d  = state_q;
    wr_pos_d = wr_pos_q;
    rd_pos_d = rd_pos_q;
    rd_ch_d  = rd_ch_q;
    data_d   = data_q;
    ce_d     = 1'b0;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    mem_addr = wr_pos_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          mem_we   = 1'b1;
          mem_addr = '0;
          if (P == 1) begin
            // A single-position frame is complete after one beat.
            wr_pos_d = '0;
            rd_pos_d = '0;
            rd_ch_d  = '0;
            state_d  = StDrain;
          end else begin
            wr_pos_d = PosW'(1);
            state_d  = StFill;
          end
        end
      end

      StFill: begin
        if (i_valid) begin
          mem_we = 1'b1;
          if (wr_pos_q == LastPos) begin
            wr_pos_d = '0;
            rd_pos_d = '0;
            rd_ch_d  = '0;
            state_d  = StDrain;
          end else begin
            wr_pos_d = wr_pos_q + 1'b1;
          end
        end
      end

      StDrain: begin
        data_d = rd_val;
        ce_d   = 1'b1;
        // The position counter is the fast index, so the order is channel-major.
        if (rd_pos_q == LastPos) begin
          rd_pos_d = '0;
          if (rd_ch_q == LastCh) begin
            rd_ch_d = '0;
            state_d = StDone;
          end else begin
            rd_ch_d = rd_ch_q + 1'b1;
          end
        end else begin
          rd_pos_d = rd_pos_q + 1'b1;
        end
        if (i_valid) begin
          ovf_d = 1'b1;
        end
      end

      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (i_valid) begin
          ovf_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, counters and registered outputs. The soft reset overrides any beat in the same cycle.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state_q  <= StIdle;
      wr_pos_q <= '0;
      rd_pos_q <= '0;
      rd_ch_q  <= '0;
      data_q   <= '0;
      ce_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (user_reset) begin
      state_q  <= StIdle;
      wr_pos_q <= '0;
      rd_pos_q <= '0;
      rd_ch_q  <= '0;
      data_q   <= '0;
      ce_q     <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_pos_q <= wr_pos_d;
      rd_pos_q <= rd_pos_d;
      rd_ch_q  <= rd_ch_d;
      data_q   <= data_d;
      ce_q     <= ce_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Write all lanes of the accepted beat into one entry. A reset beat is not stored.
  always_ff @(posedge clk) begin
    if (mem_we && !user_reset && !global_rst) begin
      for (int c = 0; c < CI; c++) begin
        mem[mem_addr][c] <= i_data[c*I_BW +: I_BW];
      end
    end
  end

  assign o_busy     = (state_q == StDrain) || (state_q == StDone);
  assign o_data     = data_q;
  assign o_ce       = ce_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_fc_flatten_buffer.sv
// Scoreboard bench for fc_flatten_buffer at default parameters.
module tb_fc_flatten_buffer;

  localparam int BW     = 16;
  localparam int I_SIZE = 4;
  localparam int CI     = 12;
  localparam int P      = I_SIZE * I_SIZE;
  localparam int N      = P * CI;

  logic               clk = 1'b0;
  logic               global_rst;
  logic               user_reset;
  logic               i_valid;
  logic [CI*BW-1:0]   i_data;
  logic               o_busy;
  logic [BW-1:0]      o_data;
  logic               o_ce;
  logic               o_done;
  logic               o_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t_last   = 0;
  int burst_idx = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;
  logic [BW-1:0] last_exp = '0;
  logic [BW-1:0] exp_q[$];

  fc_flatten_buffer #(
    .I_BW  (BW),
    .I_SIZE(I_SIZE),
    .CI    (CI)
  ) dut (
    .clk       (clk),
    .global_rst(global_rst),
    .user_reset(user_reset),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .o_busy    (o_busy),
    .o_data    (o_data),
    .o_ce      (o_ce),
    .o_done    (o_done),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] lane_val(input int kind, input int c, input int p);
    if (kind == 0) return BW'(c * P + p);
    return (c == CI - 1 && p == P - 1) ? 16'hFFFF : 16'h8000;
  endfunction

  // Drive one frame with `gap` idle cycles before each beat, then queue the flatten order.
  task automatic send_frame(input int gap, input int kind);
    for (int p = 0; p < P; p++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        i_valid = 1'b0;
      end
      @(negedge clk);
      i_valid = 1'b1;
      for (int c = 0; c < CI; c++) i_data[c*BW +: BW] = lane_val(kind, c, p);
    end
    t_last = cyc + 1;
    for (int c = 0; c < CI; c++) begin
      for (int p = 0; p < P; p++) exp_q.push_back(lane_val(kind, c, p));
    end
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    start = done_cnt;
    for (int i = 0; i < 400 && done_cnt == start; i++) @(negedge clk);
    check_eq("done_seen", done_cnt - start, 1);
    check_eq("queue_empty", exp_q.size(), 0);
  endtask

  task automatic wait_step(input int k);
    for (int i = 0; i < 400 && cyc != t_last + k; i++) @(negedge clk);
    check_eq("step_reached", cyc - t_last, k);
  endtask

  // Output monitor: pop and compare every o_ce value and check burst timing.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_ce) begin
        check_eq("ce_timing", cyc - t_last, burst_idx + 1);
        check_eq("ce_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          last_exp = exp_q.pop_front();
          check_eq("data", o_data, last_exp);
        end
        burst_idx++;
      end
      if (o_done) begin
        check_eq("done_latency", cyc - t_last, N + 1);
        check_eq("done_burst_len", burst_idx, N);
        check_eq("done_ce_low", o_ce, 0);
        check_eq("done_data_hold", o_data, last_exp);
        burst_idx = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    global_rst = 1'b1;
    user_reset = 1'b0;
    i_valid    = 1'b0;
    i_data     = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_ce", o_ce, 0);
    check_eq("rst_done", o_done, 0);
    check_eq("rst_ovf", o_overflow, 0);
    check_eq("rst_data", o_data, 0);
    global_rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Ramp on consecutive cycles.
    send_frame(0, 0);
    check_eq("busy_after_last", o_busy, 1);
    wait_done();
    check_eq("ramp_ovf", o_overflow, 0);
    check_eq("idle_after_done", o_busy, 0);

    // Same frame with a beat every third cycle.
    send_frame(2, 0);
    wait_done();
    check_eq("gap_ovf", o_overflow, 0);

    // Signed pass-through.
    send_frame(0, 1);
    wait_done();

    // A beat during the drain is dropped and sets the sticky overflow.
    send_frame(0, 0);
    wait_step(50);
    i_valid = 1'b1;
    for (int c = 0; c < CI; c++) i_data[c*BW +: BW] = 16'h1234;
    @(negedge clk);
    i_valid = 1'b0;
    check_eq("ovf_set", o_overflow, 1);
    wait_done();
    check_eq("ovf_sticky", o_overflow, 1);
    repeat (3) @(negedge clk);
    check_eq("ovf_still", o_overflow, 1);
    user_reset = 1'b1;
    @(negedge clk);
    user_reset = 1'b0;
    check_eq("ovf_cleared", o_overflow, 0);

    // global_rst mid-drain truncates the burst at once.
    send_frame(0, 0);
    wait_step(100);
    mon_en = 1'b0;
    #1 global_rst = 1'b1;
    #1;
    check_eq("grst_ce", o_ce, 0);
    check_eq("grst_busy", o_busy, 0);
    check_eq("grst_data", o_data, 0);
    exp_q.delete();
    burst_idx = 0;
    @(negedge clk);
    global_rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    send_frame(0, 0);
    wait_done();

    // user_reset with a coincident beat: the beat is not part of the frame.
    @(negedge clk);
    user_reset = 1'b1;
    i_valid    = 1'b1;
    for (int c = 0; c < CI; c++) i_data[c*BW +: BW] = 16'hDEAD;
    @(negedge clk);
    user_reset = 1'b0;
    i_valid    = 1'b0;
    check_eq("ureset_busy", o_busy, 0);
    check_eq("ureset_ovf", o_overflow, 0);
    send_frame(0, 0);
    wait_done();
    check_eq("final_ovf", o_overflow, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_flatten_buffer.md
# fc_flatten_buffer

Frame buffer and serializer in front of the fully-connected layer. Accepts pooled feature maps one pixel position per beat, with all CI channels in parallel. Stores one full frame, then replays it one value per cycle in channel-major (flatten) order on a contiguous `o_ce` burst. This burst drives the FC layer's `i_data`/`ce` inputs directly, so the FC weight index `c*I_SIZE*I_SIZE + p` lines up with the streamed value.

## Interface
- `I_BW`, 16: width of one signed feature value.
- `I_SIZE`, 4: feature-map side; P = I_SIZE*I_SIZE positions per channel.
- `CI`, 12: channel count; N = P*CI values per frame (192 at defaults).

Ports:
- `clk`  in  1  single clock, rising edge.
- `global_rst`  in  1  asynchronous, active-high reset.
- `user_reset`  in  1  synchronous soft reset, active-high.
- `i_valid`  in  1  input beat strobe.
- `i_data`  in  CI*I_BW  lane c = `i_data[c*I_BW +: I_BW]`, channel c at the current position.
- `o_busy`  out  1  high in DRAIN and DONE; beats are not accepted.
- `o_data`  out  I_BW  serialized value, registered.
- `o_ce`  out  1  qualifies `o_data`, registered.
- `o_done`  out  1  one-cycle pulse after the last `o_ce`.
- `o_overflow`  out  1  sticky flag: a beat was dropped.

## Operation
- Storage: P entries x CI lanes x I_BW registers, written at entry `wr_pos`.
- FSM states:
  - IDLE: a beat with `i_valid` is written to entry 0. `wr_pos` becomes 1 and the state goes to FILL.
  - FILL: each `i_valid` beat writes entry `wr_pos` and increments `wr_pos`. The beat with `wr_pos == P-1` is written, then the state goes to DRAIN with `rd_ch = rd_pos = 0`. Gaps between beats are allowed and have no timeout.
  - DRAIN: each cycle, register `o_data <= mem[rd_pos][rd_ch]` and set `o_ce <= 1`.
    - `rd_pos` increments and wraps at P-1 to 0.
    - On that wrap, `rd_ch` increments.
    - After `rd_ch == CI-1, rd_pos == P-1` is issued, go to DONE.
  - DONE: `o_ce <= 0`, `o_done <= 1` for one cycle, then IDLE.
- Output order: the value at step k (0..N-1) is channel k/P, position k%P. Position is raster order, row*I_SIZE+col.
- Values pass through bit-exact and signed. There is no arithmetic.
- An `i_valid` in DRAIN or DONE is dropped: memory and counters are unchanged, and `o_overflow <= 1`.
- `o_overflow` clears only on reset or `user_reset`.
- With I_SIZE = 1 (P = 1), IDLE goes straight to DRAIN on the single beat.
- Memory is not cleared on reset. Every entry is rewritten before it is read.

## Timing
- Reset values, from `global_rst` or `user_reset`:
  - outputs: `o_busy`, `o_data`, `o_ce`, `o_done`, `o_overflow` = 0.
  - internal: FSM = IDLE; `wr_pos`, `rd_pos`, `rd_ch` = 0.
- `global_rst` acts immediately and asynchronously, including mid-DRAIN. The `o_ce` burst is truncated.
- `user_reset` takes priority over all other activity at the edge. An `i_valid` in the same cycle is ignored and does not set `o_overflow`.
- Latency: the last beat is sampled at edge t. `o_ce` is high after edges t+1 … t+N, exactly N consecutive cycles with no gaps. `o_done` is high after edge t+N+1, and `o_ce` is 0 in that cycle.
- `o_busy` is high from edge t through edge t+N+1. The earliest accepted beat of the next frame is the one sampled at edge t+N+2.
- `o_data` holds its last value when `o_ce` = 0.

## Test plan
- Ramp frame, defaults: beat p, lane c = c*16+p, on consecutive cycles.
  - `o_data` = 0,1,…,191 on 192 contiguous `o_ce` cycles, the first after the edge following the last beat.
  - `o_done` is a single pulse at t+193.
  - `o_overflow` = 0.
- Gapped input: the same frame with `i_valid` on every third cycle.
  - The output sequence and latency are identical relative to the last beat.
- Signed pass-through: all lanes 0x8000 except channel 11, position 15 = 0xFFFF.
  - 191 values of 0x8000, then 0xFFFF last.
- Drop during drain: assert `i_valid` (data 0x1234) at drain step 50.
  - The output sequence is unaffected.
  - `o_overflow` = 1 from the next cycle until `user_reset`.
- `global_rst` at drain step 100:
  - `o_ce`, `o_busy`, `o_data` = 0 immediately.
  - A new ramp frame afterwards produces the full correct 192-value burst.
- `user_reset` coincident with the first beat:
  - The beat is ignored and the FSM stays IDLE.
  - The following 16 beats form the frame, verified by the ramp output.
